ci_dispatch_arbiter: RTL

Sits between the CPU custom-instruction (CI) port and two CI execution units: the tinyML accelerator (port 0) and a user-defined CI unit (port 1). It decodes each command's function ID and routes the command to one unit. It records the order of accepted commands in a tag FIFO. Responses return to the CPU strictly in issue order, so both units can be pipelined with several commands outstanding.

---
 rtl/ci_pkg.sv | 25 ++
 rtl/ci_tag_fifo.sv | 61 ++++++
 rtl/ci_dispatch_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ci_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ci_pkg                                                       |
// | Purpose : Shared port IDs, decode field positions and defaults for the |
// |           CI dispatch arbiter.                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ci_pkg;

    typedef enum logic {
        PORT_TML = 1'b0,
        PORT_USR = 1'b1
    } ci_port_e;

    localparam int          c_fid_sel_msb         = 9;
    localparam int          c_fid_sel_lsb         = 7;
    localparam logic [2:0]  c_tml_fid_msb_default = 3'b000;
    localparam logic [31:0] c_timeout_value_default = 32'hDEAD_BEEF;

    function automatic ci_port_e decode_port(input logic [9:0] fid, input logic [2:0] tml_val);
        return (fid[c_fid_sel_msb:c_fid_sel_lsb] == tml_val) ? PORT_TML : PORT_USR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ci_tag_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ci_tag_fifo                                                  |
// | Purpose : 1-bit synchronous tag FIFO recording issue order of commands.|
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ci_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [DEPTH-1:0]   r_mem;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Callers may assert push while full or pop while empty; both are ignored.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ci_dispatch_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ci_dispatch_arbiter                                          |
// | Purpose : Routes CPU CI commands to tinyML / user units and returns    |
// |           responses in issue order. Optional watchdog: CI_TIMEOUT_EN.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ci_dispatch_arbiter
    import ci_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [2:0]  TML_FID_MSB_VAL = c_tml_fid_msb_default,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] TIMEOUT_VALUE   = c_timeout_value_default
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    input  logic [9:0]                         cmd_function_id,
    input  logic [31:0]                        cmd_inputs_0,
    input  logic [31:0]                        cmd_inputs_1,
    output logic                               cmd_ready,
    output logic                               rsp_valid,
    output logic [31:0]                        rsp_outputs_0,
    input  logic                               rsp_ready,
    output logic                               tml_cmd_valid,
    output logic                               usr_cmd_valid,
    input  logic                               tml_cmd_ready,
    input  logic                               usr_cmd_ready,
    output logic [9:0]                         sub_function_id,
    output logic [31:0]                        sub_inputs_0,
    output logic [31:0]                        sub_inputs_1,
    input  logic                               tml_rsp_valid,
    input  logic                               usr_rsp_valid,
    input  logic [31:0]                        tml_rsp_outputs_0,
    input  logic [31:0]                        usr_rsp_outputs_0,
    output logic                               tml_rsp_ready,
    output logic                               usr_rsp_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_timeout
);
    localparam int c_cnt_w = $clog2(MAX_OUTSTANDING) + 1;

    ci_port_e            w_sel;
    ci_port_e            w_head;
    logic                w_head_bit;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_port_rsp_valid;
    logic [31:0]         w_port_rsp_data;
    logic [c_cnt_w-1:0]  w_count;

    assign sub_function_id = cmd_function_id;
    assign sub_inputs_0    = cmd_inputs_0;
    assign sub_inputs_1    = cmd_inputs_1;

    assign w_sel = decode_port(cmd_function_id, TML_FID_MSB_VAL);

    // Full comes from the registered count, so a same-cycle pop never frees a slot.
    assign tml_cmd_valid = cmd_valid & (w_sel == PORT_TML) & ~w_full;
    assign usr_cmd_valid = cmd_valid & (w_sel == PORT_USR) & ~w_full;
    assign cmd_ready     = ~w_full & ((w_sel == PORT_TML) ? tml_cmd_ready : usr_cmd_ready);
    assign w_push        = cmd_valid & cmd_ready;

    ci_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head_bit),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head           = ci_port_e'(w_head_bit);
    assign outstanding      = w_count;
    assign w_port_rsp_valid = (w_head == PORT_TML) ? tml_rsp_valid : usr_rsp_valid;
    assign w_port_rsp_data  = (w_head == PORT_TML) ? tml_rsp_outputs_0 : usr_rsp_outputs_0;
    assign w_pop            = rsp_valid & rsp_ready;

`ifdef CI_TIMEOUT_EN
    localparam int c_wdog_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic [c_cnt_w-1:0]  r_drop_tml;
    logic [c_cnt_w-1:0]  r_drop_usr;
    logic                r_err;
    logic                w_timed_out;
    logic                w_fwd;
    logic                w_drop_tml_act;
    logic                w_drop_usr_act;
    logic                w_inc_tml;
    logic                w_inc_usr;
    logic                w_dec_tml;
    logic                w_dec_usr;

    assign w_drop_tml_act = (r_drop_tml != '0);
    assign w_drop_usr_act = (r_drop_usr != '0);
    assign w_timed_out    = ~w_empty & (r_wdog == c_wdog_w'(TIMEOUT_CYCLES));
    // A port still owing abandoned responses must not be forwarded: its next
    // response belongs to a command that already timed out.
    assign w_fwd = ~w_empty & ~w_timed_out &
                   ((w_head == PORT_TML) ? ~w_drop_tml_act : ~w_drop_usr_act);

    always_comb begin
        rsp_valid     = w_timed_out | (w_fwd & w_port_rsp_valid);
        rsp_outputs_0 = 32'd0;
        if (w_timed_out) begin
            rsp_outputs_0 = TIMEOUT_VALUE;
        end else if (rsp_valid) begin
            rsp_outputs_0 = w_port_rsp_data;
        end
        tml_rsp_ready = w_drop_tml_act | (w_fwd & (w_head == PORT_TML) & rsp_ready);
        usr_rsp_ready = w_drop_usr_act | (w_fwd & (w_head == PORT_USR) & rsp_ready);
    end

    assign w_inc_tml = w_timed_out & rsp_ready & (w_head == PORT_TML);
    assign w_inc_usr = w_timed_out & rsp_ready & (w_head == PORT_USR);
    assign w_dec_tml = w_drop_tml_act & tml_rsp_valid;
    assign w_dec_usr = w_drop_usr_act & usr_rsp_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog     <= '0;
            r_drop_tml <= '0;
            r_drop_usr <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_wdog <= '0;
            end else if (!w_timed_out) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timed_out && rsp_ready) begin
                r_err <= 1'b1;
            end
            case ({w_inc_tml, w_dec_tml})
                2'b10:   r_drop_tml <= r_drop_tml + 1'b1;
                2'b01:   r_drop_tml <= r_drop_tml - 1'b1;
                default: r_drop_tml <= r_drop_tml;
            endcase
            case ({w_inc_usr, w_dec_usr})
                2'b10:   r_drop_usr <= r_drop_usr + 1'b1;
                2'b01:   r_drop_usr <= r_drop_usr - 1'b1;
                default: r_drop_usr <= r_drop_usr;
            endcase
        end
    end

    assign err_timeout = r_err;
`else
    logic w_unused_cfg;

    always_comb begin
        rsp_valid     = ~w_empty & w_port_rsp_valid;
        rsp_outputs_0 = rsp_valid ? w_port_rsp_data : 32'd0;
        tml_rsp_ready = ~w_empty & (w_head == PORT_TML) & rsp_ready;
        usr_rsp_ready = ~w_empty & (w_head == PORT_USR) & rsp_ready;
    end

    // Watchdog settings only matter when the timeout logic is built in.
    assign w_unused_cfg = ^{TIMEOUT_VALUE, 32'(TIMEOUT_CYCLES)};
    assign err_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire
